// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops len words from a FIFO read port and streams them
// out over valid/ready with out_last on the final beat and a done pulse.
// Ports: clk, reset (sync, active-high); start/len/busy/done control;
// r_empty/r_data/r_inc FIFO read side; out_valid/out_ready/out_data/out_last stream.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  input  logic                  r_empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_inc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  localparam logic [LEN_WIDTH-1:0] ONE  = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] ZERO = '0;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  fetch_cnt_q, fetch_cnt_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  done_q, done_d;
  logic                  pop;
  logic                  hs;

  // The output register acts as a one-entry skid: a new word may be popped
  // whenever the register is empty or is being drained this cycle.
  // Reset gates the pop so a burst aborted by reset takes nothing more.
  always_comb begin
    pop = !reset && (state_q == FETCH) && !r_empty
          && (!out_valid_q || out_ready);
    hs  = out_valid_q && out_ready;

    state_d     = state_q;
    fetch_cnt_d = fetch_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len != ZERO) begin
            state_d     = FETCH;
            fetch_cnt_d = len;
            beat_cnt_d  = len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (pop && (fetch_cnt_q == ONE)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (hs && out_last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (hs) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      beat_cnt_d  = beat_cnt_q - ONE;
    end

    // A pop in the same cycle as a handshake refills the register.
    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = r_data;
      out_last_d  = (fetch_cnt_q == ONE);
      fetch_cnt_d = fetch_cnt_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      fetch_cnt_q <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_cnt_q <= fetch_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign r_inc     = pop;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed bench with a behavioural FIFO on the read
// side, a cycle table for the basic burst and hand sequences for corners.
module tb_fifo_burst_reader;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] len;
  logic       busy;
  logic       done;
  logic       r_empty;
  logic [7:0] r_data;
  logic       r_inc;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  fifo_burst_reader #(
    .DATA_WIDTH(8),
    .LEN_WIDTH (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .r_empty  (r_empty),
    .r_data   (r_data),
    .r_inc    (r_inc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:511];
  logic [9:0] wr_ptr;
  logic [9:0] rd_ptr;
  logic [9:0] fcnt;
  logic       wr_en;
  logic [7:0] wr_val;
  logic       fifo_clr;

  initial begin
    wr_ptr = '0;
    rd_ptr = '0;
  end

  always @(posedge clk) begin
    if (fifo_clr) rd_ptr <= wr_ptr;
    else if (r_inc) rd_ptr <= rd_ptr + 10'd1;
    if (wr_en) begin
      mem[wr_ptr[8:0]] <= wr_val;
      wr_ptr <= wr_ptr + 10'd1;
    end
  end

  assign fcnt    = wr_ptr - rd_ptr;
  assign r_empty = (fcnt == 10'd0);
  assign r_data  = mem[rd_ptr[8:0]];

  int total;
  int bad;

  int         pops;
  int         hs;
  int         lasts;
  int         last_idx;
  int         dones;
  logic [7:0] got [0:511];
  logic       prev_stall;
  logic [7:0] prev_data;
  logic       prev_last;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    pops       = 0;
    hs         = 0;
    lasts      = 0;
    last_idx   = -1;
    dones      = 0;
    prev_stall = 1'b0;
  endtask

  task automatic cyc_w(input bit we, input logic [7:0] wv);
    wr_en  = we;
    wr_val = wv;
    @(negedge clk);
    if (r_inc) begin
      chk("r_inc_needs_data", int'(r_empty), 0);
      pops++;
    end
    if (prev_stall) begin
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_data", int'(out_data), int'(prev_data));
      chk("hold_last", int'(out_last), int'(prev_last));
    end
    if (out_valid && out_ready) begin
      if (hs < 512) got[hs] = out_data;
      if (out_last) begin
        lasts++;
        last_idx = hs;
      end
      hs++;
    end
    if (done) dones++;
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic cyc();
    cyc_w(1'b0, 8'h00);
  endtask

  task automatic push(input logic [7:0] v);
    wr_en  = 1'b1;
    wr_val = v;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic flush_fifo();
    fifo_clr = 1'b1;
    @(posedge clk);
    #1;
    fifo_clr = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (dones == 0 && n < bound) begin
      cyc();
      n++;
    end
    chk("done_within_bound", int'(dones != 0), 1);
  endtask

  typedef struct {
    logic       st;
    logic [7:0] ln;
    logic       rdy;
    logic       e_busy;
    logic       e_done;
    logic       e_rinc;
    logic       e_ov;
    logic [7:0] e_data;
    logic       e_last;
  } vec_t;

  vec_t tv [8];

  initial begin
    int n;
    int pushes;
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    start    = 1'b0;
    len      = 8'd0;
    out_ready = 1'b1;
    wr_en    = 1'b0;
    wr_val   = 8'h00;
    fifo_clr = 1'b0;
    clr_mon();

    tv[0] = '{1'b1, 8'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    tv[1] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    tv[2] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0};
    tv[3] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0};
    tv[4] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 1'b0};
    tv[5] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 1'b1};
    tv[6] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    tv[7] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) push(8'(i));

    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_r_inc", int'(r_inc), 0);
    chk("rst_r_empty", int'(r_empty), 0);
    @(posedge clk);
    #1;

    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      start     = tv[i].st;
      len       = tv[i].ln;
      out_ready = tv[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_busy", i), int'(busy), int'(tv[i].e_busy));
      chk($sformatf("v%0d_done", i), int'(done), int'(tv[i].e_done));
      chk($sformatf("v%0d_r_inc", i), int'(r_inc), int'(tv[i].e_rinc));
      chk($sformatf("v%0d_valid", i), int'(out_valid), int'(tv[i].e_ov));
      chk($sformatf("v%0d_last", i), int'(out_last), int'(tv[i].e_last));
      if (tv[i].e_ov)
        chk($sformatf("v%0d_data", i), int'(out_data), int'(tv[i].e_data));
      @(posedge clk);
      #1;
    end
    chk("b4_r_empty", int'(r_empty), 0);
    chk("b4_next_head", int'(r_data), 4);
    chk("b4_fifo_left", int'(fcnt), 12);

    flush_fifo();
    for (int i = 0; i < 16; i++) push(8'(i));
    clr_mon();
    start = 1'b1;
    len   = 8'd16;
    cyc();
    start = 1'b0;
    n = 0;
    while (dones == 0 && n < 100) begin
      out_ready = ~out_ready;
      cyc();
      n++;
    end
    out_ready = 1'b1;
    chk("b16_done_seen", int'(dones != 0), 1);
    chk("b16_beats", hs, 16);
    chk("b16_pops", pops, 16);
    chk("b16_lasts", lasts, 1);
    chk("b16_last_idx", last_idx, 15);
    for (int i = 0; i < 16; i++)
      chk($sformatf("b16_word%0d", i), int'(got[i]), i);
    chk("b16_fifo_empty", int'(r_empty), 1);

    clr_mon();
    start = 1'b1;
    len   = 8'd3;
    cyc();
    start = 1'b0;
    n = 0;
    while (dones == 0 && n < 60) begin
      if (n == 2) cyc_w(1'b1, 8'hA5);
      else if (n == 7) cyc_w(1'b1, 8'hB6);
      else if (n == 12) cyc_w(1'b1, 8'hC7);
      else cyc();
      n++;
    end
    chk("slow_done_seen", int'(dones != 0), 1);
    chk("slow_beats", hs, 3);
    chk("slow_pops", pops, 3);
    chk("slow_w0", int'(got[0]), 'hA5);
    chk("slow_w1", int'(got[1]), 'hB6);
    chk("slow_w2", int'(got[2]), 'hC7);
    chk("slow_lasts", lasts, 1);
    chk("slow_last_idx", last_idx, 2);

    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    start = 1'b1;
    len   = 8'd0;
    @(negedge clk);
    chk("len0_r_inc_a", int'(r_inc), 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("len0_done", int'(done), 1);
    chk("len0_busy", int'(busy), 0);
    chk("len0_valid", int'(out_valid), 0);
    chk("len0_r_inc_b", int'(r_inc), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("len0_done_clear", int'(done), 0);
    chk("len0_fifo_kept", int'(fcnt), 8);
    @(posedge clk);
    #1;

    clr_mon();
    start = 1'b1;
    len   = 8'd3;
    cyc();
    len = 8'd7;
    cyc();
    cyc();
    start = 1'b0;
    wait_done(50);
    chk("busy_start_beats", hs, 3);
    chk("busy_start_pops", pops, 3);
    chk("busy_start_last_idx", last_idx, 2);
    chk("busy_start_w0", int'(got[0]), 'h10);
    chk("busy_start_w2", int'(got[2]), 'h12);
    chk("busy_start_left", int'(fcnt), 5);
    chk("busy_start_idle", int'(busy), 0);

    flush_fifo();
    for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
    clr_mon();
    start = 1'b1;
    len   = 8'd8;
    cyc();
    start = 1'b0;
    n = 0;
    while (pops < 2 && n < 20) begin
      cyc();
      n++;
    end
    chk("abort_two_pops", pops, 2);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_r_inc_gated", int'(r_inc), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_last", int'(out_last), 0);
    chk("abort_data", int'(out_data), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_r_inc", int'(r_inc), 0);
    chk("abort_fifo_left", int'(fcnt), 6);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clr_mon();
    start = 1'b1;
    len   = 8'd6;
    cyc();
    start = 1'b0;
    wait_done(50);
    chk("resume_beats", hs, 6);
    chk("resume_last_idx", last_idx, 5);
    for (int i = 0; i < 6; i++)
      chk($sformatf("resume_w%0d", i), int'(got[i]), 'h22 + i);
    chk("resume_fifo_empty", int'(fcnt), 0);

    flush_fifo();
    clr_mon();
    start  = 1'b1;
    len    = 8'd255;
    cyc_w(1'b1, 8'h00);
    start  = 1'b0;
    pushes = 1;
    n = 0;
    while (dones == 0 && n < 600) begin
      if (pushes < 300) begin
        cyc_w(1'b1, 8'(pushes));
        pushes++;
      end else begin
        cyc();
      end
      n++;
    end
    chk("max_done_seen", int'(dones != 0), 1);
    chk("max_beats", hs, 255);
    chk("max_pops", pops, 255);
    chk("max_lasts", lasts, 1);
    chk("max_last_idx", last_idx, 254);
    for (int i = 0; i < 255; i++)
      chk($sformatf("max_w%0d", i), int'(got[i]), i & 255);
    chk("max_fifo_left", int'(fcnt), pushes - 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of FIFO and stream data.
REQ-002 SHALL have parameter LEN_WIDTH, default 8, width of burst length and beat counters.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port start  input  1  burst request, sampled only in IDLE.
REQ-007 SHALL have port len  input  LEN_WIDTH  beats to transfer, sampled with start.
REQ-008 SHALL have port busy  output  1  high while a burst is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-010 SHALL have port r_empty  input  1  FIFO empty flag from the sync_fifo read side.
REQ-011 SHALL have port r_data  input  DATA_WIDTH  FIFO head word, valid whenever r_empty is low.
REQ-012 SHALL have port r_inc  output  1  FIFO pop; head word consumed on a clk edge with r_inc high.
REQ-013 SHALL have port out_valid  output  1  stream word valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts; handshake = out_valid & out_ready.
REQ-015 SHALL have port out_data  output  DATA_WIDTH  stream word.
REQ-016 SHALL have port out_last  output  1  marks final beat of the burst, qualified by out_valid.

Function
REQ-017 SHALL implement states IDLE, FETCH, DRAIN.
REQ-018 IDLE + start + len!=0 -> FETCH; fetch counter = len, beat counter = len; busy high from the next cycle.
REQ-019 IDLE + start + len==0 -> stay IDLE; done pulses the next cycle; no r_inc, no out_valid.
REQ-020 start outside IDLE SHALL be ignored; len SHALL be sampled only on the accepted start cycle.
REQ-021 r_inc SHALL be combinational: state==FETCH & !r_empty & (!out_valid | out_ready).
REQ-022 On r_inc: out_data <= r_data, out_valid <= 1, out_last <= (fetch counter==1), fetch counter decrements.
REQ-023 Latency: FIFO word popped at edge N SHALL appear on out_data with out_valid high after edge N.
REQ-024 Throughput: with r_empty low and out_ready high, one beat per cycle, no bubbles.
REQ-025 out_valid, out_data, out_last SHALL hold stable while out_valid & !out_ready.
REQ-026 Handshake without a new pop SHALL clear out_valid and out_last.
REQ-027 FETCH -> DRAIN on the pop where fetch counter==1; DRAIN issues no r_inc.
REQ-028 Handshake with out_last high SHALL move to IDLE; done pulses and busy drops the following cycle.
REQ-029 r_empty high in FETCH SHALL stall with no r_inc; the held output word is unaffected.
REQ-030 Counters SHALL be LEN_WIDTH bits; len = 2^LEN_WIDTH-1 SHALL transfer exactly that many beats, no wrap.
REQ-031 Total r_inc pulses per burst SHALL equal len; total handshakes SHALL equal len; exactly one with out_last.

Reset
REQ-032 While reset is high: state IDLE, counters 0, busy 0, done 0, out_valid 0, out_last 0, out_data 0, r_inc 0.
REQ-033 Reset mid-burst SHALL abort with no further pops; unread FIFO words remain in the FIFO.
REQ-034 First start accepted on the first cycle after reset deasserts.

Verification
REQ-035 Post-reset: busy=0, done=0, out_valid=0, r_inc=0 with r_empty=0.
REQ-036 FIFO preloaded 0..15, len=4, out_ready=1 -> out_data 0,1,2,3 on 4 consecutive cycles, out_last on 3, one done pulse, r_empty=0 after, next head 4.
REQ-037 FIFO of DEPTH 16 filled with 0..15, len=16, out_ready toggling 1/0 -> all 16 words in order, each held stable while stalled, FIFO r_empty=1 at end.
REQ-038 len=3, FIFO empty, write A5, B6, C7 spaced 5 cycles apart -> r_inc only when r_empty=0; stream A5, B6, C7, out_last on C7.
REQ-039 start with len=0 -> done next cycle, zero r_inc, zero out_valid; start during a busy burst -> no effect on len or beat count.
REQ-040 reset asserted after 2 of 8 beats -> outputs cleared the next cycle, FIFO retains exactly 6 words, new burst len=6 returns them in order.
